// File: rtl/pad_gpio_pkg.sv
// Shared definitions for the padring-side GPIO controller: register map,
// bus widths, the register request payload and the filter counter width.
package pad_gpio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_OUT          = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OEN          = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IE           = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_IN           = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_INTR_STATE   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_INTR_EN_RISE = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_INTR_EN_FALL = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_RSVD         = 3'd7;

  // One register bus request as seen on the cycle it is presented.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_req_t;

  // Filter counter width: clog2 of the stability window, at least one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pad_gpio_filter.sv
// One pin's input conditioning: two-flop synchronizer, stability filter and
// rise/fall detection on the filtered level.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   raw_i           pad input already gated by input enable
//   filt_o          filtered level (registered)
//   rise_c_o        combinational: filtered level went 0->1 on the last edge
//   fall_c_o        combinational: filtered level went 1->0 on the last edge
module pad_gpio_filter
  import pad_gpio_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned     CW      = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed from filt for FILT_CYCLES
  // consecutive samples; any return to the current level restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o   = filt_q;
  assign rise_c_o = filt_q & ~prev_q;
  assign fall_c_o = ~filt_q & prev_q;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// Core-side GPIO controller for one padring side: register file driving the
// pad output bundle, filtered input path and a level interrupt.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   reg_req_i/we_i/addr_i/wdata_i single-cycle register request
//   reg_rvalid_o, reg_rdata_o     read response one cycle after a read
//   pad_din_i                     raw pad input
//   pad_dout_o/oen_o/ie_o         pad data, active-low enable, input enable
//   pad_tech_cfg_o                constant tech configuration
//   intr_o                        level interrupt, OR of pending state
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
  parameter int unsigned             NPINS       = 9,
  parameter int unsigned             CFGW        = 18,
  parameter int unsigned             FILT_CYCLES = 4,
  parameter logic [NPINS*CFGW-1:0]   CFG_DEFAULT = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    reg_req_i,
  input  logic                    reg_we_i,
  input  logic [ADDR_W-1:0]       reg_addr_i,
  input  logic [DATA_W-1:0]       reg_wdata_i,
  output logic                    reg_rvalid_o,
  output logic [DATA_W-1:0]       reg_rdata_o,
  input  logic [NPINS-1:0]        pad_din_i,
  output logic [NPINS-1:0]        pad_dout_o,
  output logic [NPINS-1:0]        pad_oen_o,
  output logic [NPINS-1:0]        pad_ie_o,
  output logic [NPINS*CFGW-1:0]   pad_tech_cfg_o,
  output logic                    intr_o
);

  reg_req_t         req;
  logic             wr, rd;
  logic [NPINS-1:0] wbits;
  logic             unused_wdata;

  logic [NPINS-1:0] out_q, out_d;
  logic [NPINS-1:0] oen_q, oen_d;
  logic [NPINS-1:0] ie_q, ie_d;
  logic [NPINS-1:0] state_q, state_d;
  logic [NPINS-1:0] en_rise_q, en_rise_d;
  logic [NPINS-1:0] en_fall_q, en_fall_d;
  logic             intr_q, intr_d;
  logic             rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [NPINS-1:0] raw, filt, rise, fall, clr;

  assign req   = '{we: reg_we_i, addr: reg_addr_i, wdata: reg_wdata_i};
  assign wr    = reg_req_i & req.we;
  assign rd    = reg_req_i & ~req.we;
  assign wbits = req.wdata[NPINS-1:0];
  // Write data bits above NPINS are architecturally ignored.
  assign unused_wdata = ^req.wdata;

  // Disabled inputs read as 0 before entering the synchronizer.
  assign raw = pad_din_i & ie_q;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    pad_gpio_filter #(
      .FILT_CYCLES(FILT_CYCLES)
    ) u_filter (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .raw_i    (raw[i]),
      .filt_o   (filt[i]),
      .rise_c_o (rise[i]),
      .fall_c_o (fall[i])
    );
  end

  // Register writes, W1C with set-wins priority, and read response.
  always_comb begin
    out_d     = out_q;
    oen_d     = oen_q;
    ie_d      = ie_q;
    en_rise_d = en_rise_q;
    en_fall_d = en_fall_q;
    clr       = '0;
    rvalid_d  = rd;
    rdata_d   = '0;

    if (wr) begin
      case (req.addr)
        ADDR_OUT:          out_d     = wbits;
        ADDR_OEN:          oen_d     = wbits;
        ADDR_IE:           ie_d      = wbits;
        ADDR_INTR_STATE:   clr       = wbits;
        ADDR_INTR_EN_RISE: en_rise_d = wbits;
        ADDR_INTR_EN_FALL: en_fall_d = wbits;
        default: ;
      endcase
    end

    state_d = (state_q & ~clr) | (rise & en_rise_q) | (fall & en_fall_q);
    intr_d  = |state_q;

    if (rd) begin
      case (req.addr)
        ADDR_OUT:          rdata_d = DATA_W'(out_q);
        ADDR_OEN:          rdata_d = DATA_W'(oen_q);
        ADDR_IE:           rdata_d = DATA_W'(ie_q);
        ADDR_IN:           rdata_d = DATA_W'(filt);
        ADDR_INTR_STATE:   rdata_d = DATA_W'(state_q);
        ADDR_INTR_EN_RISE: rdata_d = DATA_W'(en_rise_q);
        ADDR_INTR_EN_FALL: rdata_d = DATA_W'(en_fall_q);
        ADDR_RSVD:         rdata_d = '0;
        default:           rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q     <= '0;
      oen_q     <= '1;
      ie_q      <= '0;
      state_q   <= '0;
      en_rise_q <= '0;
      en_fall_q <= '0;
      intr_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      oen_q     <= oen_d;
      ie_q      <= ie_d;
      state_q   <= state_d;
      en_rise_q <= en_rise_d;
      en_fall_q <= en_fall_d;
      intr_q    <= intr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pad_dout_o     = out_q;
  assign pad_oen_o      = oen_q;
  assign pad_ie_o       = ie_q;
  assign pad_tech_cfg_o = CFG_DEFAULT;
  assign intr_o         = intr_q;
  assign reg_rvalid_o   = rvalid_q;
  assign reg_rdata_o    = rdata_q;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Self-checking bench for pad_gpio_ctrl. A behavioural model tracks the
// register file, the filtered inputs (as "last FILT_CYCLES synchronized
// samples all disagree with the current level") and the interrupt state.
module tb_pad_gpio_ctrl;
  import pad_gpio_pkg::*;

  localparam int unsigned NP  = 9;
  localparam int unsigned CFG = 18;
  localparam int unsigned FC  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req, we;
  logic [2:0]        addr;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [NP-1:0]     din, dout, oen, ie;
  logic [NP*CFG-1:0] tcfg;
  logic              intr;

  pad_gpio_ctrl #(
    .NPINS(NP), .CFGW(CFG), .FILT_CYCLES(FC), .CFG_DEFAULT('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_rvalid_o(rvalid), .reg_rdata_o(rdata),
    .pad_din_i(din), .pad_dout_o(dout), .pad_oen_o(oen), .pad_ie_o(ie),
    .pad_tech_cfg_o(tcfg), .intr_o(intr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [NP-1:0] m_out, m_oen, m_ie, m_in, m_state, m_er, m_ef, m_pr, m_pf;
  logic          m_intr, m_rvalid;
  logic [31:0]   m_rdata;
  logic [NP-1:0] rawq [0:FC];   // rawq[0] = raw value sampled on the latest edge

  task automatic model_reset();
    m_out = '0; m_oen = '1; m_ie = '0; m_in = '0; m_state = '0;
    m_er = '0; m_ef = '0; m_pr = '0; m_pf = '0;
    m_intr = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    for (int j = 0; j <= FC; j++) rawq[j] = '0;
  endtask

  function automatic logic [31:0] read_val(input logic [2:0] a);
    case (a)
      ADDR_OUT:          return 32'(m_out);
      ADDR_OEN:          return 32'(m_oen);
      ADDR_IE:           return 32'(m_ie);
      ADDR_IN:           return 32'(m_in);
      ADDR_INTR_STATE:   return 32'(m_state);
      ADDR_INTR_EN_RISE: return 32'(m_er);
      ADDR_INTR_EN_FALL: return 32'(m_ef);
      default:           return 32'd0;
    endcase
  endfunction

  task automatic bus(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
  endtask

  // Advance the model by one clock edge, then let the DUT take the same edge.
  task automatic tick();
    logic [NP-1:0] raw, w, clr, nin;
    logic          wr, rd;
    bit            flip;
    raw = din & m_ie;
    wr  = req & we;
    rd  = req & ~we;
    w   = wdata[NP-1:0];
    m_rvalid = rd;
    m_rdata  = rd ? read_val(addr) : 32'd0;
    m_intr   = |m_state;
    clr      = (wr && addr == ADDR_INTR_STATE) ? w : '0;
    m_state  = (m_state & ~clr) | (m_pr & m_er) | (m_pf & m_ef);
    nin = m_in;
    for (int p = 0; p < NP; p++) begin
      flip = 1'b1;
      for (int j = 1; j <= FC; j++) if (rawq[j][p] == m_in[p]) flip = 1'b0;
      if (flip) nin[p] = ~m_in[p];
    end
    m_pr = nin & ~m_in;
    m_pf = ~nin & m_in;
    m_in = nin;
    if (wr) begin
      case (addr)
        ADDR_OUT:          m_out = w;
        ADDR_OEN:          m_oen = w;
        ADDR_IE:           m_ie  = w;
        ADDR_INTR_EN_RISE: m_er  = w;
        ADDR_INTR_EN_FALL: m_ef  = w;
        default: ;
      endcase
    end
    for (int j = FC; j >= 1; j--) rawq[j] = rawq[j-1];
    rawq[0] = raw;
    @(posedge clk);
    #1;
    bus(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (oen !== 9'h1FF) begin errors++; $display("FAIL reset_oen: got %0h expected 1ff", oen); end
    checks++; if (dout !== 9'h000) begin errors++; $display("FAIL reset_dout: got %0h expected 0", dout); end
    checks++; if (ie !== 9'h000) begin errors++; $display("FAIL reset_ie: got %0h expected 0", ie); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %0b expected 0", intr); end
    checks++; if (rvalid !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp: got %0b/%0h expected 0/0", rvalid, rdata); end
    checks++; if (tcfg !== '0) begin errors++; $display("FAIL reset_tcfg: got %0h expected 0", tcfg); end
    for (int a = 0; a < 8; a++) begin
      bus(1'b1, 1'b0, 3'(a), 32'd0);
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== ((a == 1) ? 32'h1FF : 32'd0)) begin
        errors++; $display("FAIL reset_read[%0d]: got %0b/%0h expected 1/%0h", a, rvalid, rdata, (a == 1) ? 32'h1FF : 32'd0);
      end
    end
    // Reset asserted across a write edge must suppress the write.
    bus(1'b1, 1'b1, ADDR_OUT, 32'h1FF);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus(1'b0, 1'b0, 3'd0, 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    checks++; if (dout !== 9'h000) begin errors++; $display("FAIL reset_midwrite_dout: got %0h expected 0", dout); end
    bus(1'b1, 1'b0, ADDR_OUT, 32'd0);
    tick();
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_midwrite_read: got %0h expected 0", rdata); end
  endtask

  task automatic test_regs();
    bus(1'b1, 1'b1, ADDR_OUT, 32'hABCD_E0A5);
    tick();
    checks++; if (dout !== 9'h0A5) begin errors++; $display("FAIL regs_dout: got %0h expected a5", dout); end
    bus(1'b1, 1'b1, ADDR_OEN, 32'h0000_0150);
    tick();
    checks++; if (oen !== 9'h150) begin errors++; $display("FAIL regs_oen: got %0h expected 150", oen); end
    bus(1'b1, 1'b0, ADDR_OUT, 32'd0);
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h0A5) begin errors++; $display("FAIL regs_read_out: got %0b/%0h expected 1/a5", rvalid, rdata); end
    bus(1'b1, 1'b0, ADDR_OEN, 32'd0);
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h150) begin errors++; $display("FAIL regs_read_oen: got %0b/%0h expected 1/150", rvalid, rdata); end
    tick();
    checks++; if (rvalid !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL regs_idle: got %0b/%0h expected 0/0", rvalid, rdata); end
  endtask

  task automatic test_filter();
    bus(1'b1, 1'b1, ADDR_IE, 32'h001);
    tick();
    repeat (8) tick();
    din[0] = 1'b1;
    repeat (5) tick();
    bus(1'b1, 1'b0, ADDR_IN, 32'd0);
    tick();   // response reflects IN after edge 5
    checks++; if (rdata[0] !== 1'b0 || rdata !== m_rdata) begin errors++; $display("FAIL filt_edge5: got %0h expected bit0=0 (%0h)", rdata, m_rdata); end
    bus(1'b1, 1'b0, ADDR_IN, 32'd0);
    tick();   // response reflects IN after edge 6
    checks++; if (rdata[0] !== 1'b1 || rdata !== m_rdata) begin errors++; $display("FAIL filt_edge6: got %0h expected bit0=1 (%0h)", rdata, m_rdata); end
    din[0] = 1'b0;
    repeat (10) tick();
    din[0] = 1'b1;
    repeat (3) tick();
    din[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus(1'b1, 1'b0, ADDR_IN, 32'd0);
      tick();
      checks++; if (rdata[0] !== 1'b0 || rdata !== m_rdata) begin errors++; $display("FAIL filt_glitch[%0d]: got %0h expected bit0=0 (%0h)", k, rdata, m_rdata); end
    end
    din[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus(1'b1, 1'b0, ADDR_IN, 32'd0);
      tick();
      checks++; if (rdata[1] !== 1'b0 || rdata !== m_rdata) begin errors++; $display("FAIL filt_ie_off[%0d]: got %0h expected bit1=0 (%0h)", k, rdata, m_rdata); end
    end
    din = '0;
    repeat (8) tick();
  endtask

  task automatic test_intr();
    int n;
    bus(1'b1, 1'b1, ADDR_IE, 32'h1FF);
    tick();
    bus(1'b1, 1'b1, ADDR_INTR_EN_RISE, 32'h004);
    tick();
    repeat (8) tick();
    din[2] = 1'b1;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      checks++; if (intr !== m_intr) begin errors++; $display("FAIL intr_track[%0d]: got %0b expected %0b", n, intr, m_intr); end
      if (intr === 1'b1) break;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL intr_latency: got %0d edges expected 8", n); end
    bus(1'b1, 1'b0, ADDR_INTR_STATE, 32'd0);
    tick();
    checks++; if (rdata !== 32'h004) begin errors++; $display("FAIL intr_state: got %0h expected 4", rdata); end
    bus(1'b1, 1'b1, ADDR_INTR_STATE, 32'h004);
    tick();
    tick();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL intr_clear: got %0b expected 0", intr); end
    bus(1'b1, 1'b0, ADDR_INTR_STATE, 32'd0);
    tick();
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL intr_state_clr: got %0h expected 0", rdata); end
  endtask

  task automatic test_w1c_race();
    int k;
    din[2] = 1'b0;
    repeat (10) tick();
    din[2] = 1'b1;
    k = 0;
    while (m_pr[2] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++; if (k >= 20) begin errors++; $display("FAIL race_timeout: got %0d edges expected < 20", k); end
    bus(1'b1, 1'b1, ADDR_INTR_STATE, 32'h004);
    tick();
    bus(1'b1, 1'b0, ADDR_INTR_STATE, 32'd0);
    tick();
    checks++; if ((rdata & 32'h4) !== 32'h4 || rdata !== m_rdata) begin errors++; $display("FAIL race_set_wins: got %0h expected bit2=1 (%0h)", rdata, m_rdata); end
    bus(1'b1, 1'b1, ADDR_INTR_EN_FALL, 32'h002);
    tick();
    bus(1'b1, 1'b1, ADDR_INTR_STATE, 32'hFFFF_FFFF);
    tick();
    din[1] = 1'b1;
    repeat (10) tick();
    din[1] = 1'b0;
    repeat (10) tick();
    bus(1'b1, 1'b0, ADDR_INTR_STATE, 32'd0);
    tick();
    checks++; if (rdata !== 32'h002) begin errors++; $display("FAIL fall_intr: got %0h expected 2", rdata); end
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL fall_intr_o: got %0b expected 1", intr); end
  endtask

  task automatic test_reserved();
    bus(1'b1, 1'b1, ADDR_RSVD, 32'hFFFF_FFFF);
    tick();
    checks++; if (dout !== m_out || oen !== m_oen || ie !== m_ie) begin errors++; $display("FAIL rsvd_pads: got %0h/%0h/%0h expected %0h/%0h/%0h", dout, oen, ie, m_out, m_oen, m_ie); end
    for (int a = 7; a >= 0; a--) begin
      bus(1'b1, 1'b0, 3'(a), 32'd0);
      tick();
      checks++; if (rvalid !== 1'b1 || rdata !== m_rdata) begin errors++; $display("FAIL rsvd_read[%0d]: got %0b/%0h expected 1/%0h", a, rvalid, rdata, m_rdata); end
      if (a == 7) begin
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rsvd_zero: got %0h expected 0", rdata); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) din = NP'($urandom);
      if ($urandom_range(1) == 1) bus(1'b1, 1'($urandom), 3'($urandom), $urandom);
      tick();
      checks++; if (dout !== m_out || oen !== m_oen || ie !== m_ie) begin errors++; $display("FAIL rnd_pads[%0d]: got %0h/%0h/%0h expected %0h/%0h/%0h", c, dout, oen, ie, m_out, m_oen, m_ie); end
      checks++; if (intr !== m_intr) begin errors++; $display("FAIL rnd_intr[%0d]: got %0b expected %0b", c, intr, m_intr); end
      checks++; if (rvalid !== m_rvalid || rdata !== m_rdata) begin errors++; $display("FAIL rnd_rsp[%0d]: got %0b/%0h expected %0b/%0h", c, rvalid, rdata, m_rvalid, m_rdata); end
    end
    checks++; if (tcfg !== '0) begin errors++; $display("FAIL rnd_tcfg: got %0h expected 0", tcfg); end
  endtask

  initial begin
    din = '0;
    bus(1'b0, 1'b0, 3'd0, 32'd0);
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_regs();
    test_filter();
    test_intr();
    test_w1c_race();
    test_reserved();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
